keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner_pkg.sv | 49 ++++
 rtl/keypad_scanner_sync2.sv | 30 +++
 rtl/keypad_scanner.sv | 202 ++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/keypad_scanner_pkg.sv
// Shared keypad definitions: matrix geometry, FSM state encoding, keycode layout.
// No latency (types, constants and pure functions only).
// No flow control; used by keypad_scanner and keypad_interpreter.
package keypad_scanner_pkg;

    localparam int NUM_COLS  = 5;
    localparam int NUM_ROWS  = 4;
    localparam int COL_IDX_W = 3;
    localparam int ROW_IDX_W = 2;

    // Keycode layout: {row_index, col_index}
    localparam int KC_W       = ROW_IDX_W + COL_IDX_W;
    localparam int KC_COL_LSB = 0;
    localparam int KC_COL_MSB = COL_IDX_W - 1;
    localparam int KC_ROW_LSB = COL_IDX_W;
    localparam int KC_ROW_MSB = KC_W - 1;

    typedef enum logic [2:0] {
        ST_SCAN     = 3'd0,
        ST_DEBOUNCE = 3'd1,
        ST_PRESSED  = 3'd2,
        ST_HOLD     = 3'd3,
        ST_RELEASE  = 3'd4
    } kp_state_e;

    function automatic logic [KC_W-1:0] make_keycode(
        input logic [ROW_IDX_W-1:0] row_idx,
        input logic [COL_IDX_W-1:0] col_idx
    );
        logic [KC_W-1:0] kc;
        kc = '0;
        kc[KC_ROW_MSB:KC_ROW_LSB] = row_idx;
        kc[KC_COL_MSB:KC_COL_LSB] = col_idx;
        return kc;
    endfunction

    // Active-low column drive: exactly one bit low for a legal index.
    function automatic logic [NUM_COLS-1:0] col_drive(input logic [COL_IDX_W-1:0] col_idx);
        logic [NUM_COLS-1:0] drv;
        drv = '1;
        for (int i = 0; i < NUM_COLS; i++) begin
            if (col_idx == COL_IDX_W'(i)) begin
                drv[i] = 1'b0;
            end
        end
        return drv;
    endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Parameterised-width two-flop synchronizer for asynchronous level inputs.
// Latency: 2 clock cycles.
// No backpressure; samples every cycle.
// Ports: clock, reset (async active-low), d_i (async input), q_o (synchronized output).
module sync2 #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 5x4 matrix keypad scanner with debounced press/release and one-shot key report.
// Latency: accept DEBOUNCE_CNT dwells after the first detecting sample plus 1 cycle.
// No backpressure: newkey is a single-cycle pulse, keycode held until the next press.
// Ports: clock, reset (async active-low), col (active-low column drive),
//        row (active-low async row sense), newkey (1-cycle pulse), keycode {row,col}.
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,  // cycles per column dwell, minimum 4
    parameter int DEBOUNCE_CNT = 20     // identical samples to accept press/release
) (
    input  logic                clock,
    input  logic                reset,
    output logic [NUM_COLS-1:0] col,
    input  logic [NUM_ROWS-1:0] row,
    output logic                newkey,
    output logic [KC_W-1:0]     keycode
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);

    localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0]     DIV_ONE  = DIV_W'(1);
    localparam logic [CNT_W-1:0]     CNT_MAX  = CNT_W'(DEBOUNCE_CNT);
    localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
    localparam logic [COL_IDX_W-1:0] COL_LAST = COL_IDX_W'(NUM_COLS - 1);
    localparam logic [COL_IDX_W-1:0] COL_ONE  = COL_IDX_W'(1);

    // ------------------------------------------------------------------
    // Row synchronizer: idle (pulled-up) rows reset to all ones.
    // ------------------------------------------------------------------
    logic [NUM_ROWS-1:0] rs;

    sync2 #(
        .WIDTH   (NUM_ROWS),
        .RST_VAL ({NUM_ROWS{1'b1}})
    ) u_row_sync (
        .clock (clock),
        .reset (reset),
        .d_i   (row),
        .q_o   (rs)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    kp_state_e              state_q,   state_d;
    logic [DIV_W-1:0]       div_q,     div_d;
    logic [CNT_W-1:0]       cnt_q,     cnt_d;
    logic [COL_IDX_W-1:0]   col_idx_q, col_idx_d;
    logic [ROW_IDX_W-1:0]   row_idx_q, row_idx_d;
    logic                   newkey_q,  newkey_d;
    logic [KC_W-1:0]        keycode_q, keycode_d;

    // ------------------------------------------------------------------
    // Dwell timer: free-running, sample strobe on the last dwell cycle.
    // The >= compare keeps it from running past the terminal value.
    // ------------------------------------------------------------------
    logic sample;

    always_comb begin
        sample = (div_q >= DIV_LAST);
        div_d  = sample ? '0 : (div_q + DIV_ONE);
    end

    // ------------------------------------------------------------------
    // Row decode: one-hot-low to index, plus "exactly one" / "none" flags.
    // ------------------------------------------------------------------
    logic [2:0]           low_cnt;
    logic [ROW_IDX_W-1:0] row_hit;
    logic                 one_low;
    logic                 all_high;

    always_comb begin
        low_cnt = '0;
        row_hit = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (!rs[r]) begin
                low_cnt = low_cnt + 3'd1;
                row_hit = ROW_IDX_W'(r);
            end
        end
        one_low  = (low_cnt == 3'd1);
        all_high = &rs;
    end

    logic [COL_IDX_W-1:0] col_next;
    assign col_next = (col_idx_q >= COL_LAST) ? '0 : (col_idx_q + COL_ONE);

    // ------------------------------------------------------------------
    // FSM next state. The column index doubles as the latched column of
    // a candidate key: it is simply not advanced outside SCAN, which
    // also freezes the column drive.
    // Counters only increment while below CNT_MAX, so they saturate.
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        col_idx_d = col_idx_q;
        row_idx_d = row_idx_q;
        newkey_d  = 1'b0;
        keycode_d = keycode_q;

        case (state_q)
            ST_SCAN: begin
                if (sample) begin
                    if (one_low) begin
                        row_idx_d = row_hit;
                        cnt_d     = CNT_ONE;
                        state_d   = ST_DEBOUNCE;
                    end else begin
                        col_idx_d = col_next;
                    end
                end
            end

            ST_DEBOUNCE: begin
                if (sample) begin
                    if (one_low && (row_hit == row_idx_q)) begin
                        if (cnt_q >= CNT_MAX) begin
                            // newkey/keycode are registered here so they
                            // are valid during the single PRESSED cycle.
                            state_d   = ST_PRESSED;
                            cnt_d     = '0;
                            newkey_d  = 1'b1;
                            keycode_d = make_keycode(row_idx_q, col_idx_q);
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end else begin
                        state_d   = ST_SCAN;
                        cnt_d     = '0;
                        col_idx_d = col_next;
                    end
                end
            end

            ST_PRESSED: begin
                state_d = ST_HOLD;
            end

            ST_HOLD: begin
                if (sample && all_high) begin
                    state_d = ST_RELEASE;
                    cnt_d   = CNT_ONE;
                end
            end

            ST_RELEASE: begin
                if (sample) begin
                    if (all_high) begin
                        if (cnt_q >= CNT_MAX) begin
                            state_d   = ST_SCAN;
                            cnt_d     = '0;
                            col_idx_d = col_next;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end else begin
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                    end
                end
            end

            default: begin
                state_d   = ST_SCAN;
                cnt_d     = '0;
                col_idx_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_SCAN;
            div_q     <= '0;
            cnt_q     <= '0;
            col_idx_q <= '0;
            row_idx_q <= '0;
            newkey_q  <= 1'b0;
            keycode_q <= '0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            col_idx_q <= col_idx_d;
            row_idx_q <= row_idx_d;
            newkey_q  <= newkey_d;
            keycode_q <= keycode_d;
        end
    end

    assign col     = col_drive(col_idx_q);
    assign newkey  = newkey_q;
    assign keycode = keycode_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CNT=3.
// A keypad model turns a pressed-key matrix into row levels for the driven column.
// Cycle numbers k count rising edges since reset release, observed on the falling edge.
module tb_keypad_scanner;

    logic        clock;
    logic        reset;
    logic [4:0]  col;
    logic [3:0]  row;
    logic        newkey;
    logic [4:0]  keycode;

    logic [19:0] keys;      // bit r*5+c set = key (row r, col c) pressed
    int          cyc;
    int          n_checks;
    int          n_pass;
    int          nk_cnt;
    logic [4:0]  nk_kc [8];
    int          nk_at [8];

    keypad_scanner #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CNT (3)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .col     (col),
        .row     (row),
        .newkey  (newkey),
        .keycode (keycode)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Keypad matrix: a row is pulled low when a pressed key sits on the driven column.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            row[r] = ~(|(keys[r*5 +: 5] & ~col));
        end
    end

    always @(posedge clock or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Pulse log: every high cycle of newkey is one entry.
    initial nk_cnt = 0;
    always @(negedge clock) begin
        if (!reset) begin
            nk_cnt = 0;
        end else if (newkey) begin
            if (nk_cnt < 8) begin
                nk_kc[nk_cnt] = keycode;
                nk_at[nk_cnt] = cyc;
            end
            nk_cnt = nk_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (k=%0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [19:0] kbit(input int r, input int c);
        logic [19:0] v;
        v = '0;
        v[r*5 + c] = 1'b1;
        return v;
    endfunction

    task automatic at(input int k);
        while (cyc < k) @(negedge clock);
    endtask

    task automatic do_reset(input logic [19:0] k);
        @(negedge clock);
        reset = 1'b0;
        keys  = k;
        repeat (3) @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] scan_exp [6];
        scan_exp[0] = 5'b11110; scan_exp[1] = 5'b11101; scan_exp[2] = 5'b11011;
        scan_exp[3] = 5'b10111; scan_exp[4] = 5'b01111; scan_exp[5] = 5'b11110;
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b0;
        keys     = '0;

        // Reset state
        repeat (2) @(negedge clock);
        check("rst_col", col, 5'b11110);
        check("rst_newkey", newkey, 0);
        check("rst_keycode", keycode, 0);
        reset = 1'b1;

        // Idle scan order 0..4 and wrap, 4 cycles per column
        for (int i = 0; i < 6; i++) begin
            at(4*i + 2);
            check("scan_order", col, scan_exp[i]);
        end

        // Row 2 on col 3: detect at k=16, accept pulse at k=28
        do_reset(kbit(2, 3));
        at(27); check("r2c3_pre", newkey, 0);
        at(28); check("r2c3_pulse", newkey, 1);
        check("r2c3_code", keycode, 5'b10_011);
        check("r2c3_col", col, 5'b10111);
        at(29); check("r2c3_post", newkey, 0);
        at(60); check("r2c3_once", nk_cnt, 1);
        check("r2c3_frozen", col, 5'b10111);
        keys = '0;
        at(75); check("r2c3_rel_hold", col, 5'b10111);
        at(76); check("r2c3_rel_scan", col, 5'b01111);

        // Press (r1,c1), detected at k=88; reset mid-debounce
        keys = kbit(1, 1);
        at(90); check("dbn_frozen", col, 5'b11101);
        check("kc_held", keycode, 5'b10_011);
        #2 reset = 1'b0;
        #1;
        check("arst_col", col, 5'b11110);
        check("arst_newkey", newkey, 0);
        check("arst_keycode", keycode, 0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        at(2);  check("restart_col0", col, 5'b11110);
        at(19); check("r1c1_pre", newkey, 0);
        at(20); check("r1c1_pulse", newkey, 1);
        check("r1c1_code", keycode, 5'b01_001);

        // Bouncing row 1 on col 0, toggling every 5 cycles
        do_reset(kbit(1, 0));
        at(5);  keys = '0;
        at(7);  check("bounce_dbn_col", col, 5'b11110);
        at(9);  check("bounce_resume", col, 5'b11101);
        for (int i = 2; i <= 20; i++) begin
            at(5*i);
            keys = keys ^ kbit(1, 0);
        end
        at(101); check("bounce_nokey", nk_cnt, 0);

        // Two rows low on col 2: rejected, scan continues
        do_reset(kbit(0, 2) | kbit(3, 2));
        at(13); check("multi_adv", col, 5'b10111);
        at(33); check("multi_cycle", col, 5'b10111);
        at(60); check("multi_nokey", nk_cnt, 0);

        // (r3,c4) held with a one-dwell release glitch, then final release
        do_reset(kbit(3, 4));
        at(32); check("glitch_pulse", newkey, 1);
        check("glitch_code", keycode, 5'b11_100);
        at(60); keys = '0;
        at(64); keys = kbit(3, 4);
        at(100); check("glitch_hold", col, 5'b01111);
        at(120); keys = '0;
        at(135); check("glitch_rel_hold", col, 5'b01111);
        at(136); check("glitch_wrap", col, 5'b11110);
        check("glitch_once", nk_cnt, 1);

        // Back-to-back presses (r0,c0) then (r3,c4)
        do_reset(kbit(0, 0));
        at(16); check("b2b_pulse0", newkey, 1);
        at(20); keys = '0;
        at(35); check("b2b_rel_hold", col, 5'b11110);
        at(36); check("b2b_rel_scan", col, 5'b11101);
        keys = kbit(3, 4);
        at(64); check("b2b_pulse1", newkey, 1);
        at(66); keys = '0;
        at(70);
        check("b2b_count", nk_cnt, 2);
        check("b2b_at0", nk_at[0], 16);
        check("b2b_kc0", nk_kc[0], 5'b00_000);
        check("b2b_at1", nk_at[1], 64);
        check("b2b_kc1", nk_kc[1], 5'b11_100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
